// File: rtl/spi_slave_interface.sv
// SPI slave front end: deserialises 10-bit command frames for a memory stage and
// serialises 8-bit read data back out on MISO.
module spi_slave_interface (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t     r_state, w_next;
    logic       r_rd_addr_rcvd;
    logic [9:0] r_rx_sr;
    logic [9:0] r_rx_data;
    logic       r_rx_valid;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_tx_sr;
    logic [3:0] r_tx_cnt;
    logic       r_tx_done;
    logic       w_shifting;
    logic       w_tx_load;

    assign w_shifting = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
    // Read data is accepted only once the read frame is complete, and only once per frame.
    assign w_tx_load  = (r_state == READ_DATA) && !SS_n && (r_bit_cnt == 4'd10)
                        && !r_tx_done && tx_valid;

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign MISO     = (r_tx_cnt != 4'd0) && r_tx_sr[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!SS_n) w_next = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)                w_next = IDLE;
                else if (!MOSI)          w_next = WRITE;
                else if (r_rd_addr_rcvd) w_next = READ_DATA;
                else                     w_next = READ_ADD;
            end
            default: if (SS_n) w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr_rcvd <= 1'b0;
            r_rx_sr        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_bit_cnt      <= '0;
            r_tx_sr        <= '0;
            r_tx_cnt       <= '0;
            r_tx_done      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            // SS_n high wins over everything, including a 10th bit arriving on this edge.
            if (SS_n || !w_shifting) begin
                r_rx_sr   <= '0;
                r_bit_cnt <= '0;
                r_tx_sr   <= '0;
                r_tx_cnt  <= '0;
                r_tx_done <= 1'b0;
            end else begin
                if (r_bit_cnt != 4'd10) begin
                    r_rx_sr   <= {r_rx_sr[8:0], MOSI};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                if (r_bit_cnt == 4'd9) begin
                    r_rx_data  <= {r_rx_sr[8:0], MOSI};
                    r_rx_valid <= 1'b1;
                    if (r_state == READ_ADD)  r_rd_addr_rcvd <= 1'b1;
                    if (r_state == READ_DATA) r_rd_addr_rcvd <= 1'b0;
                end
                if (w_tx_load) begin
                    r_tx_sr   <= tx_data;
                    r_tx_cnt  <= 4'd8;
                    r_tx_done <= 1'b1;
                end else if (r_tx_cnt != 4'd0) begin
                    r_tx_sr  <= {r_tx_sr[6:0], 1'b0};
                    r_tx_cnt <= r_tx_cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_interface.sv
// Directed bench for spi_slave_interface: write, read address/data, aborts,
// spurious tx_valid and asynchronous reset.
module tb_spi_slave_interface;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int total = 0;
    int bad   = 0;
    int pulses;

    spi_slave_interface dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // SS_n low, decision bit, then 10 frame bits MSB first; returns just after the 10th capture.
    task automatic send_frame(input logic dec, input logic [9:0] w);
        SS_n = 1'b0;
        tick();
        MOSI = dec;
        tick();
        for (int i = 9; i >= 0; i--) begin
            MOSI = w[i];
            tick();
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] rd;
        logic [9:0] w;
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        #12;
        chk("reset_miso", MISO, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        rst_n = 1'b1;
        tick();

        // Write frame 0x0A5; rx_valid must appear exactly 11 clocks after CHK_CMD entry.
        w = 10'h0A5;
        SS_n = 1'b0; tick();
        MOSI = 1'b0; tick();
        for (int i = 9; i >= 1; i--) begin
            MOSI = w[i]; tick();
        end
        chk("wr_no_early_valid", rx_valid, 0);
        tx_valid = 1'b1; tx_data = 8'hFF;
        MOSI = w[0]; tick();
        chk("wr_rx_valid", rx_valid, 1);
        chk("wr_rx_data", rx_data, 10'h0A5);
        chk("wr_spurious_tx_miso", MISO, 0);
        // Extra bits with SS_n still low must not produce another strobe.
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            MOSI = i[0]; tick();
            if (rx_valid) pulses++;
            chk("wr_spurious_tx_miso_hold", MISO, 0);
        end
        tx_valid = 1'b0;
        chk("wr_extra_bits_pulses", pulses, 0);
        chk("wr_rx_data_hold", rx_data, 10'h0A5);
        end_frame();

        // Spurious tx_valid in IDLE.
        tx_valid = 1'b1; tick(); tick();
        chk("idle_spurious_tx_miso", MISO, 0);
        tx_valid = 1'b0;

        // Read address frame.
        send_frame(1'b1, 10'h203);
        chk("rda_rx_valid", rx_valid, 1);
        chk("rda_rx_data", rx_data, 10'h203);
        tx_valid = 1'b1; tx_data = 8'hAA; tick();
        tx_valid = 1'b0;
        chk("rda_tx_ignored", MISO, 0);
        tick();
        chk("rda_valid_one_cycle", rx_valid, 0);
        end_frame();

        // Read data frame, then serialise 0xC3.
        send_frame(1'b1, 10'h3C5);
        chk("rdd_rx_valid", rx_valid, 1);
        chk("rdd_rx_data", rx_data, 10'h3C5);
        chk("rdd_miso_before_latch", MISO, 0);
        tx_valid = 1'b1; tx_data = 8'hC3; tick();
        tx_data = 8'h00;
        rd = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            chk($sformatf("rdd_miso_bit%0d", i), MISO, rd[i]);
            tick();
        end
        chk("rdd_miso_after", MISO, 0);
        tx_data = 8'hFF; tick(); tick();
        chk("rdd_second_tx_ignored", MISO, 0);
        tx_valid = 1'b0;
        end_frame();

        // Flag cleared: decision bit 1 goes back to READ_ADD (tx_valid ignored).
        send_frame(1'b1, 10'h211);
        chk("flag_clr_rx_data", rx_data, 10'h211);
        tx_valid = 1'b1; tx_data = 8'hFF; tick(); tick();
        chk("flag_clr_read_add", MISO, 0);
        tx_valid = 1'b0;
        end_frame();
        // Flag now set; close it with a read data frame without sending data.
        send_frame(1'b1, 10'h300);
        chk("rdd2_rx_data", rx_data, 10'h300);
        end_frame();

        // Abort after 5 payload bits in WRITE.
        w = 10'h155;
        SS_n = 1'b0; tick();
        MOSI = 1'b0; tick();
        for (int i = 9; i >= 5; i--) begin
            MOSI = w[i]; tick();
        end
        end_frame();
        pulses = 0;
        if (rx_valid) pulses++;
        tick();
        if (rx_valid) pulses++;
        chk("abort5_no_valid", pulses, 0);
        chk("abort5_rx_data", rx_data, 10'h300);

        // SS_n rising on the 10th-bit edge aborts the frame.
        w = 10'h0FF;
        SS_n = 1'b0; tick();
        MOSI = 1'b0; tick();
        for (int i = 9; i >= 1; i--) begin
            MOSI = w[i]; tick();
        end
        SS_n = 1'b1; MOSI = w[0]; tick();
        chk("abort10_no_valid", rx_valid, 0);
        chk("abort10_rx_data", rx_data, 10'h300);
        tick();

        // Async reset mid READ_DATA shift.
        send_frame(1'b1, 10'h203);
        end_frame();
        send_frame(1'b1, 10'h3AB);
        tx_valid = 1'b1; tx_data = 8'hFF; tick();
        tx_valid = 1'b0;
        tick(); tick(); tick();
        chk("rst_pre_miso", MISO, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_miso", MISO, 0);
        chk("rst_async_rx_data", rx_data, 0);
        chk("rst_async_rx_valid", rx_valid, 0);
        #1 rst_n = 1'b1;
        SS_n = 1'b1;
        tick();
        send_frame(1'b1, 10'h2C1);
        chk("post_rst_rx_valid", rx_valid, 1);
        chk("post_rst_rx_data", rx_data, 10'h2C1);
        tx_valid = 1'b1; tx_data = 8'hFF; tick(); tick();
        chk("post_rst_read_add", MISO, 0);
        tx_valid = 1'b0;
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
